// File: rtl/btb_pkg.sv
// Shared types and helpers for the set-associative BTB: entry layout,
// PC field extraction and saturating direction-counter arithmetic.
package btb_pkg;

    // Entry fields are sized for the widest legal configuration; the top
    // level only ever writes values that fit its own TAG_PC_LEN/CNT_LEN.
    localparam int TAG_MAX = 30;
    localparam int CNT_MAX = 8;

    typedef struct packed {
        logic               valid;
        logic [TAG_MAX-1:0] tag;
        logic [31:0]        target;
        logic [CNT_MAX-1:0] cnt;
    } btb_entry_t;

    function automatic logic [CNT_MAX-1:0] cnt_weak_taken(input int cnt_len);
        return CNT_MAX'(32'd1 << (cnt_len - 1));
    endfunction

    function automatic logic [31:0] set_index(input logic [31:0] pc, input int set_len);
        return (pc >> 2) & ((32'd1 << set_len) - 32'd1);
    endfunction

    function automatic logic [TAG_MAX-1:0] pc_tag(input logic [31:0] pc, input int set_len,
                                                 input int tag_len);
        return TAG_MAX'((pc >> (set_len + 2)) & ((32'd1 << tag_len) - 32'd1));
    endfunction

    function automatic logic [CNT_MAX-1:0] sat_inc(input logic [CNT_MAX-1:0] c, input int cnt_len);
        logic [CNT_MAX-1:0] max_v;
        max_v = CNT_MAX'((32'd1 << cnt_len) - 32'd1);
        return (c == max_v) ? c : c + 1'b1;
    endfunction

    function automatic logic [CNT_MAX-1:0] sat_dec(input logic [CNT_MAX-1:0] c);
        return (c == '0) ? c : c - 1'b1;
    endfunction

endpackage

// File: rtl/btb_lru_set.sv
// LRU age update for one set: ages form a permutation of 0..WAYS-1, the
// touched way becomes youngest and the oldest way is the replacement victim.
module btb_lru_set #(
    parameter int WAYS  = 2,
    parameter int WAY_W = 1
) (
    input  logic [WAYS-1:0][WAY_W-1:0] ages,
    input  logic                       touch,
    input  logic [WAY_W-1:0]           touch_way,
    output logic [WAY_W-1:0]           victim,
    output logic [WAYS-1:0][WAY_W-1:0] ages_next
);

    always_comb begin
        victim = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (ages[w] == WAY_W'(WAYS - 1))
                victim = WAY_W'(w);
        end
    end

    // Only ways younger than the touched one age, which keeps the permutation.
    always_comb begin
        ages_next = ages;
        if (touch) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == touch_way)
                    ages_next[w] = '0;
                else if (ages[w] < ages[touch_way])
                    ages_next[w] = ages[w] + 1'b1;
            end
        end
    end

endmodule

// File: rtl/btb_assoc_bht.sv
// Set-associative BTB with saturating direction counters and LRU allocation.
// Define BTB_STATS_EN to build the lookup/hit/update statistics counters.
module btb_assoc_bht
    import btb_pkg::*;
#(
    parameter int SET_ADDR_LEN = 5,
    parameter int WAYS         = 2,
    parameter int TAG_PC_LEN   = 8,
    parameter int CNT_LEN      = 2,
    parameter int STAT_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lookup_en,
    input  logic [31:0]       PC_IF,
    output logic              isHit_BTB,
    output logic              predTaken,
    output logic [31:0]       predictedPC,
    input  logic              wr_req,
    input  logic [31:0]       PC_EX,
    input  logic [31:0]       PC_Branch,
    input  logic              isTakenBr_Ex,
    input  logic              flush,
    output logic [STAT_W-1:0] stat_lookups,
    output logic [STAT_W-1:0] stat_hits,
    output logic [STAT_W-1:0] stat_updates
);

    localparam int SETS  = 1 << SET_ADDR_LEN;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    btb_entry_t mem [SETS][WAYS];

    logic [SET_ADDR_LEN-1:0] if_set, ex_set;
    logic [TAG_MAX-1:0]      if_tag, ex_tag;

    assign if_set = SET_ADDR_LEN'(set_index(PC_IF, SET_ADDR_LEN));
    assign ex_set = SET_ADDR_LEN'(set_index(PC_EX, SET_ADDR_LEN));
    assign if_tag = pc_tag(PC_IF, SET_ADDR_LEN, TAG_PC_LEN);
    assign ex_tag = pc_tag(PC_EX, SET_ADDR_LEN, TAG_PC_LEN);

    // IF lookup: allocation only on miss keeps matches one-hot, so OR-merge is safe.
    logic               hit;
    logic [31:0]        hit_tgt;
    logic [CNT_MAX-1:0] hit_cnt;

    always_comb begin
        hit     = 1'b0;
        hit_tgt = '0;
        hit_cnt = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (mem[if_set][w].valid && mem[if_set][w].tag == if_tag) begin
                hit     = 1'b1;
                hit_tgt = hit_tgt | mem[if_set][w].target;
                hit_cnt = hit_cnt | mem[if_set][w].cnt;
            end
        end
    end

    assign isHit_BTB   = hit;
    assign predTaken   = hit & (|(hit_cnt >> (CNT_LEN - 1)));
    assign predictedPC = hit_tgt;

    // EX side: hit way, lowest invalid way, and the resulting touch target.
    logic             ex_hit, has_free, do_touch;
    logic [WAY_W-1:0] ex_way, free_way, victim, alloc_way, touch_way;

    always_comb begin
        ex_hit   = 1'b0;
        ex_way   = '0;
        has_free = 1'b0;
        free_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (mem[ex_set][w].valid && mem[ex_set][w].tag == ex_tag) begin
                ex_hit = 1'b1;
                ex_way = WAY_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!mem[ex_set][w].valid) begin
                has_free = 1'b1;
                free_way = WAY_W'(w);
            end
        end
    end

    assign alloc_way = has_free ? free_way : victim;
    assign touch_way = ex_hit ? ex_way : alloc_way;
    assign do_touch  = wr_req & ~flush & (ex_hit | isTakenBr_Ex);

    generate
        if (WAYS > 1) begin : g_lru
            logic [SETS-1:0][WAYS-1:0][WAY_W-1:0] age_q;
            logic [WAYS-1:0][WAY_W-1:0]           age_next;

            btb_lru_set #(.WAYS(WAYS), .WAY_W(WAY_W)) u_lru (
                .ages      (age_q[ex_set]),
                .touch     (do_touch),
                .touch_way (touch_way),
                .victim    (victim),
                .ages_next (age_next)
            );

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int s = 0; s < SETS; s++)
                        for (int w = 0; w < WAYS; w++)
                            age_q[s][w] <= WAY_W'(w);
                end else if (do_touch) begin
                    age_q[ex_set] <= age_next;
                end
            end
        end else begin : g_no_lru
            assign victim = '0;
        end
    endgenerate

    // Flush keeps payloads and only drops valid bits; reset clears everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    mem[s][w] <= '0;
        end else if (flush) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    mem[s][w].valid <= 1'b0;
        end else if (wr_req) begin
            if (ex_hit) begin
                if (isTakenBr_Ex) begin
                    mem[ex_set][ex_way].cnt    <= sat_inc(mem[ex_set][ex_way].cnt, CNT_LEN);
                    mem[ex_set][ex_way].target <= PC_Branch;
                end else begin
                    mem[ex_set][ex_way].cnt    <= sat_dec(mem[ex_set][ex_way].cnt);
                end
            end else if (isTakenBr_Ex) begin
                mem[ex_set][alloc_way].valid  <= 1'b1;
                mem[ex_set][alloc_way].tag    <= ex_tag;
                mem[ex_set][alloc_way].target <= PC_Branch;
                mem[ex_set][alloc_way].cnt    <= cnt_weak_taken(CNT_LEN);
            end
        end
    end

`ifdef BTB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_lookups <= '0;
            stat_hits    <= '0;
            stat_updates <= '0;
        end else begin
            if (lookup_en && stat_lookups != '1)
                stat_lookups <= stat_lookups + 1'b1;
            if (lookup_en && hit && stat_hits != '1)
                stat_hits <= stat_hits + 1'b1;
            if (wr_req && !flush && stat_updates != '1)
                stat_updates <= stat_updates + 1'b1;
        end
    end
`else
    assign stat_lookups = '0;
    assign stat_hits    = '0;
    assign stat_updates = '0;
    logic unused_stat;
    assign unused_stat = lookup_en;
`endif

endmodule
